// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Main control FSM for a multi-cycle MIPS-subset datapath. It fetches an
// instruction, decodes opcode/funct, sequences the execute, memory and
// write-back steps, and counts retired instructions.
//
// Ports
//   clk          : system clock, rising-edge active
//   reset_n      : asynchronous active-low reset
//   opcode[5:0]  : IR[31:26]
//   funct[5:0]   : IR[5:0]
//   alu_zero     : ALU result == 0
//   mem_ready    : memory access completes in a cycle where this is 1
//   ext_sel[1:0] : immediate extender 00 sign, 01 zero, 10 lui
//   alu_op[1:0]  : 00 add, 01 sub, 10 or
//   alu_b_sel    : 0 rt, 1 extended immediate
//   mem_read, mem_write, ir_write, pc_write, reg_write : active-high strobes
//   pc_src[1:0]  : 00 pc+4, 01 branch target, 10 jump target, 11 rs
//   reg_dst[1:0] : 00 rt, 01 rd, 10 $31
//   wd_sel[1:0]  : 00 ALU, 01 memory, 10 pc+4
//   state[3:0]   : current state (debug)
//   instr_count  : retired instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [1:0]  ext_sel,
  output logic [1:0]  alu_op,
  output logic        alu_b_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_WB_I     = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  logic [3:0]  r_state;
  logic [3:0]  w_next_state;
  logic [31:0] r_instr_count;

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        w_next_state = S_FETCH;  // unknown encodings retire as a NOP
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU) w_next_state = S_EXEC_R;
            else if (funct == FN_JR)                  w_next_state = S_JUMP;
          end
          OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
          OP_BEQ:         w_next_state = S_BRANCH;
          OP_J, OP_JAL:   w_next_state = S_JUMP;
          default:        w_next_state = S_FETCH;
        endcase
      end
      S_EXEC_R:   w_next_state = S_WB_R;
      S_EXEC_I:   w_next_state = S_WB_I;
      S_MEM_ADDR: w_next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next_state = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;  // WB_*, BRANCH, JUMP, unused codes
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      // An instruction retires on every return to FETCH; wraps naturally.
      if (w_next_state == S_FETCH && r_state != S_FETCH)
        r_instr_count <= r_instr_count + 32'd1;
    end
  end

  // Output decode. Purely combinational so strobes line up with the state
  // that owns them; everything is gated by reset_n so FETCH does not issue
  // a memory read while the block is held in reset.
  always_comb begin
    ext_sel   = 2'b00;
    alu_op    = 2'b00;
    alu_b_sel = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_src    = 2'b00;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    if (reset_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC_R: alu_op = (funct == FN_SUBU) ? 2'b01 : 2'b00;
        S_EXEC_I: begin
          alu_b_sel = 1'b1;
          if (opcode == OP_LUI) begin
            ext_sel = 2'b10;          // upper immediate + $0
          end else begin
            ext_sel = 2'b01;
            alu_op  = 2'b10;
          end
        end
        S_MEM_ADDR: alu_b_sel = 1'b1;
        S_MEM_RD:   mem_read  = 1'b1;
        S_MEM_WR:   mem_write = 1'b1;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_WB_I:     reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write = 1'b1;
          wd_sel    = 2'b01;
        end
        S_BRANCH: begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_write = alu_zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          if (opcode == OP_RTYPE) begin
            pc_src = 2'b11;           // jr
          end else begin
            pc_src = 2'b10;
            if (opcode == OP_JAL) begin
              reg_write = 1'b1;
              reg_dst   = 2'b10;
              wd_sel    = 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Directed bench for multi_cycle_ctrl. Inputs change just after the falling
// edge; outputs are checked 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        mem_ready;
  logic [1:0]  ext_sel;
  logic [1:0]  alu_op;
  logic        alu_b_sel;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  pc_src;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  multi_cycle_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .ext_sel     (ext_sel),
    .alu_op      (alu_op),
    .alu_b_sel   (alu_b_sel),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .pc_src      (pc_src),
    .reg_dst     (reg_dst),
    .wd_sel      (wd_sel),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance one clock and land at the checking point.
  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  // No strobe at all.
  task automatic check_quiet(input string tag);
    check({tag, " strobes"},
          {27'd0, mem_read, mem_write, ir_write, pc_write, reg_write}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;

    // ---- reset state -------------------------------------------------------
    #12;
    check("rst state", state, 0);
    check("rst count", instr_count, 0);
    check_quiet("rst");

    // ---- FETCH holds while memory is not ready ----------------------------
    @(negedge clk);
    reset_n = 1'b1;
    opcode  = 6'h23;                         // lw
    #1;
    check("fetch wait mem_read", mem_read, 1);
    check("fetch wait ir_write", ir_write, 0);
    nc();
    check("fetch hold state", state, 0);
    mem_ready = 1'b1;
    #1;
    check("fetch ir_write", ir_write, 1);
    check("fetch pc_write", pc_write, 1);
    check("fetch pc_src", pc_src, 0);

    // ---- lw: 0,1,4,5,9,0 ---------------------------------------------------
    nc(); check("lw decode", state, 1);
    nc(); check("lw mem_addr", state, 4);
    check("lw ma ext_sel", ext_sel, 0);
    check("lw ma alu_b_sel", alu_b_sel, 1);
    check("lw ma alu_op", alu_op, 0);
    nc(); check("lw mem_rd", state, 5);
    check("lw mem_read", mem_read, 1);
    nc(); check("lw wb_mem", state, 9);
    check("lw wb reg_write", reg_write, 1);
    check("lw wb wd_sel", wd_sel, 1);
    check("lw wb reg_dst", reg_dst, 0);
    nc(); check("lw done state", state, 0);
    check("lw count", instr_count, 1);

    // ---- ori ---------------------------------------------------------------
    opcode = 6'h0D;
    nc(); check("ori decode", state, 1);
    nc(); check("ori exec_i", state, 3);
    check("ori ext_sel", ext_sel, 1);
    check("ori alu_op", alu_op, 2);
    check("ori alu_b_sel", alu_b_sel, 1);
    nc(); check("ori wb_i", state, 8);
    check("ori wb reg_write", reg_write, 1);
    check("ori wb reg_dst", reg_dst, 0);
    check("ori wb wd_sel", wd_sel, 0);
    nc(); check("ori count", instr_count, 2);

    // ---- lui ---------------------------------------------------------------
    opcode = 6'h0F;
    nc(); nc(); check("lui exec_i", state, 3);
    check("lui ext_sel", ext_sel, 2);
    check("lui alu_op", alu_op, 0);
    nc(); nc(); check("lui fetch", state, 0);
    check("lui count", instr_count, 3);

    // ---- beq taken: 3 cycles ----------------------------------------------
    opcode   = 6'h04;
    alu_zero = 1'b1;
    nc(); nc(); check("beq1 branch", state, 10);
    check("beq1 pc_write", pc_write, 1);
    check("beq1 pc_src", pc_src, 1);
    check("beq1 alu_op", alu_op, 1);
    check("beq1 alu_b_sel", alu_b_sel, 0);
    nc(); check("beq1 fetch", state, 0);
    check("beq1 count", instr_count, 4);

    // ---- beq not taken -----------------------------------------------------
    alu_zero = 1'b0;
    nc(); nc(); check("beq0 branch", state, 10);
    check("beq0 pc_write", pc_write, 0);
    check("beq0 pc_src", pc_src, 1);
    alu_zero = 1'b1;                         // pc_write follows alu_zero directly
    #1;
    check("beq0 comb pc_write", pc_write, 1);
    alu_zero = 1'b0;
    nc(); check("beq0 fetch", state, 0);
    check("beq0 count", instr_count, 5);

    // ---- sw with 3 wait cycles --------------------------------------------
    opcode = 6'h2B;
    nc(); nc(); check("sw mem_addr", state, 4);
    mem_ready = 1'b0;
    nc(); check("sw wr1 state", state, 6);
    check("sw wr1 mem_write", mem_write, 1);
    nc(); check("sw wr2 mem_write", mem_write, 1);
    nc(); check("sw wr3 mem_write", mem_write, 1);
    mem_ready = 1'b1;
    #1;
    check("sw wr4 state", state, 6);
    check("sw wr4 mem_write", mem_write, 1);
    nc(); check("sw fetch", state, 0);
    check("sw fetch mem_write", mem_write, 0);
    check("sw count", instr_count, 6);

    // ---- jal ---------------------------------------------------------------
    opcode = 6'h03;
    nc(); nc(); check("jal jump", state, 11);
    check("jal pc_write", pc_write, 1);
    check("jal pc_src", pc_src, 2);
    check("jal reg_write", reg_write, 1);
    check("jal reg_dst", reg_dst, 2);
    check("jal wd_sel", wd_sel, 2);
    nc(); check("jal count", instr_count, 7);

    // ---- jr ----------------------------------------------------------------
    opcode = 6'h00;
    funct  = 6'h08;
    nc(); nc(); check("jr jump", state, 11);
    check("jr pc_src", pc_src, 3);
    check("jr reg_write", reg_write, 0);
    nc(); check("jr count", instr_count, 8);

    // ---- addu / subu -------------------------------------------------------
    funct = 6'h21;
    nc(); nc(); check("addu exec_r", state, 2);
    check("addu alu_op", alu_op, 0);
    check("addu alu_b_sel", alu_b_sel, 0);
    nc(); check("addu wb_r", state, 7);
    check("addu reg_write", reg_write, 1);
    check("addu reg_dst", reg_dst, 1);
    nc(); check("addu count", instr_count, 9);
    funct = 6'h23;
    nc(); nc(); check("subu alu_op", alu_op, 1);
    nc(); nc(); check("subu count", instr_count, 10);

    // ---- undefined opcode: 2 cycles, no strobes in DECODE ------------------
    opcode = 6'h3F;
    funct  = 6'h00;
    nc(); check("undef decode", state, 1);
    check_quiet("undef");
    nc(); check("undef fetch", state, 0);
    check("undef count", instr_count, 11);

    // ---- reset pulsed during MEM_RD ----------------------------------------
    opcode = 6'h23;
    nc(); nc();
    mem_ready = 1'b0;
    nc(); check("rstmid mem_rd", state, 5);
    check("rstmid mem_read on", mem_read, 1);
    #2;
    reset_n = 1'b0;                          // between clock edges
    #1;
    check("rstmid async state", state, 0);
    check("rstmid async count", instr_count, 0);
    check("rstmid mem_read off", mem_read, 0);
    nc(); check("rstmid held state", state, 0);
    check_quiet("rstmid held");
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rstmid resume mem_read", mem_read, 1);
    check("rstmid resume count", instr_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
